// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl
// ----------------------------------------------------------------------------
// Central stall/flush sequencer for the 5-stage pipeline. It owns no datapath.
// It drives the load-enable and flush/bubble controls of the PC and of the
// IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It resolves:
//   - load-use hazards: one bubble is inserted into ID/EX;
//   - EX-stage redirects: IF/ID and ID/EX are flushed;
//   - data-memory wait states: the whole front end freezes, and MEM/WB
//     takes a NOP;
//   - external halt: the pipe is drained for 4 cycles and then frozen.
//
// Optional build macro:
//   HAZARD_PERF_CNT_EN  When defined, the stall-cycle and flush counters are
//                       instantiated. When undefined, the perf ports are tied
//                       to 0.
//
// Handshake: dmem_ready is sampled only while a MEM access is pending.
//   - A cycle with mem_req=1 and dmem_ready=0 is a wait cycle.
//   - The cycle in which dmem_ready=1 is the completion cycle. MEM/WB
//     captures the memory result in that cycle.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   id_rs1/id_rs2         source register indices of the ID instruction
//   id_uses_rs1/2         ID instruction actually reads rs1/rs2
//   ex_rd                 destination register of the EX instruction
//   ex_is_load            EX instruction is a load
//   ex_reg_write          EX instruction writes rd
//   ex_redirect           taken branch / jump resolved in EX
//   mem_req               MEM instruction accesses data memory
//   dmem_ready            data memory completes the access this cycle
//   halt_req              level-sensitive debug halt request
//   pc_en .. ex_mem_en    stage-register load enables and flushes
//   mem_wb_bubble         MEM/WB loads a NOP
//   halted                core frozen
//   mem_timeout_err       sticky memory timeout error
//   perf_stall_cycles     front-end stall cycles in RUN/MEM_WAIT
//   perf_flush_count      cycles with id_ex_flush asserted
//   dbg_state             current sequencer state, for observation only
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  ex_reg_write,
    input  logic                  ex_redirect,
    input  logic                  mem_req,
    input  logic                  dmem_ready,
    input  logic                  halt_req,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_en,
    output logic                  id_ex_flush,
    output logic                  ex_mem_en,
    output logic                  mem_wb_bubble,
    output logic                  halted,
    output logic                  mem_timeout_err,
    output logic [CNT_W-1:0]      perf_stall_cycles,
    output logic [CNT_W-1:0]      perf_flush_count,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [1:0] S_HALTED   = 2'd3;

    localparam int                WCNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcnt_nxt;
    logic [WCNT_W-1:0] w_wcnt_inc;
    logic [1:0]        r_dcnt;
    logic [1:0]        w_dcnt_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              w_rs1_hit;
    logic              w_rs2_hit;
    logic              w_lu;
    logic              w_freeze;

    assign w_rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign w_lu       = ex_is_load && ex_reg_write && (ex_rd != '0) && (w_rs1_hit || w_rs2_hit);
    assign w_wcnt_inc = r_wcnt + 1'b1;

    // Once MEM_WAIT is entered, the access is known to be pending.
    // Only dmem_ready decides release there. In RUN and DRAIN, a wait starts
    // when a request sees a not-ready memory.
    assign w_freeze = (r_state == S_MEM_WAIT) ? !dmem_ready : (mem_req && !dmem_ready);

    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b0;
        halted        = 1'b0;
        w_state_nxt   = r_state;
        w_wcnt_nxt    = r_wcnt;
        w_dcnt_nxt    = r_dcnt;
        w_err_nxt     = r_err;

        if (reset) begin
            if (r_state != S_HALTED && w_freeze) begin
                // Memory wait: freeze everything up to EX/MEM. MEM/WB keeps
                // clocking, so it takes a NOP. A concurrent redirect or
                // load-use is ignored here. EX is frozen, so the same
                // condition is seen again after release.
                mem_wb_bubble = 1'b1;
                w_wcnt_nxt    = w_wcnt_inc;
                if (w_wcnt_inc == WCNT_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_HALTED;
                end else if (r_state != S_DRAIN) begin
                    w_state_nxt = S_MEM_WAIT;
                end
                // Inside DRAIN the wait is handled in place and dcnt holds.
            end else begin
                case (r_state)
                    S_RUN, S_MEM_WAIT: begin
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        ex_mem_en = 1'b1;
                        if (ex_redirect) begin
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                        end else if (w_lu) begin
                            // Hold PC and IF/ID; inject one bubble into ID/EX.
                            pc_en       = 1'b0;
                            if_id_en    = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                        w_wcnt_nxt = '0;
                        if (halt_req) begin
                            w_state_nxt = S_DRAIN;
                            w_dcnt_nxt  = 2'd0;
                        end else begin
                            w_state_nxt = S_RUN;
                        end
                    end
                    S_DRAIN: begin
                        // The PC stays put, so the instruction in IF at drain
                        // entry is refetched on resume. NOPs enter behind the
                        // instructions that are draining.
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_en    = 1'b1;
                        id_ex_flush = ex_redirect;
                        ex_mem_en   = 1'b1;
                        w_wcnt_nxt  = '0;
                        w_dcnt_nxt  = r_dcnt + 2'd1;
                        if (r_dcnt == 2'd3) begin
                            w_state_nxt = S_HALTED;
                        end
                    end
                    default: begin
                        halted        = 1'b1;
                        mem_wb_bubble = 1'b1;
                        // A timeout halt can only be left through reset.
                        if (!halt_req && !r_err) begin
                            w_state_nxt = S_RUN;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_RUN;
            r_wcnt  <= '0;
            r_dcnt  <= 2'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign mem_timeout_err = r_err;
    assign dbg_state       = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_en && (r_state == S_RUN || r_state == S_MEM_WAIT)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (id_ex_flush) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign perf_stall_cycles = r_stall_cnt;
    assign perf_flush_count  = r_flush_cnt;
`else
    assign perf_stall_cycles = '0;
    assign perf_flush_count  = '0;
`endif

endmodule
